// File: rtl/i2c_txn_scheduler.sv
// Arbitrates host one-shot commands and periodic ADT7420 temperature polls onto one I2C engine.
// Define I2C_SCHED_POLL_EN to build the poll timer, poll requester and round-robin arbitration.
module i2c_txn_scheduler #(
    parameter logic [31:0] POLL_PERIOD    = 32'd100_000_000,
    parameter logic [6:0]  DEV_ADDR       = 7'h48,
    parameter logic [7:0]  TEMP_REG       = 8'h00,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        host_trig,
    input  logic        host_rnw,
    input  logic [7:0]  host_reg,
    input  logic [15:0] host_wdata,
    input  logic [1:0]  host_len,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_err,
    output logic [15:0] host_rdata,
    output logic [15:0] temperature,
    output logic        temp_valid,
    output logic        eng_start,
    output logic        eng_abort,
    output logic        eng_rnw,
    output logic [6:0]  eng_dev_addr,
    output logic [7:0]  eng_reg,
    output logic [15:0] eng_wdata,
    output logic [1:0]  eng_len,
    input  logic        eng_done,
    input  logic        eng_ack_err,
    input  logic [15:0] eng_rdata,
    output logic [7:0]  state
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 8;
    localparam int unsigned WDOG_W = 24;

    typedef enum logic [7:0] {
        S_IDLE     = 8'h00,
        S_ARB      = 8'h01,
        S_ISSUE    = 8'h02,
        S_WAIT     = 8'h03,
        S_COMPLETE = 8'h04,
        S_TIMEOUT  = 8'h05
    } state_t;

    typedef struct packed {
        logic              rnw;
        logic [REG_W-1:0]  regaddr;
        logic [DATA_W-1:0] wdata;
        logic [1:0]        len;
    } cmd_t;

    state_t            cur_state, next_state;
    cmd_t              host_cmd, poll_cmd;
    logic              host_trig_q, host_edge;
    logic              host_pending, host_pending_d;
    logic              poll_pending, poll_pending_d, poll_wrap;
    logic              last_poll, owner_host, owner_host_d;
    logic              grant_host, grant_poll;
    logic [WDOG_W-1:0] wdog, wdog_inc;

    assign host_edge = host_trig & ~host_trig_q;
    assign wdog_inc  = wdog + WDOG_W'(1);
    assign state     = cur_state;
    assign poll_cmd  = '{rnw: 1'b1, regaddr: TEMP_REG, wdata: '0, len: 2'd2};

`ifdef I2C_SCHED_POLL_EN
    logic [31:0] poll_cnt;

    // Free-running poll period counter; only reset clears it.
    assign poll_wrap = (poll_cnt == POLL_PERIOD - 32'd1);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) poll_cnt <= '0;
        else        poll_cnt <= poll_wrap ? '0 : poll_cnt + 32'd1;
    end
`else
    logic unused_poll;
    assign poll_wrap   = 1'b0;
    assign unused_poll = ^POLL_PERIOD;
`endif

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_IDLE;
        else        cur_state <= next_state;
    end

    // Next state, grant and pending-flag updates; a fresh edge/wrap leaves IDLE straight away.
    always_comb begin
        next_state = cur_state;
        grant_host = 1'b0;
        grant_poll = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (host_pending || host_edge || poll_pending || poll_wrap) next_state = S_ARB;
            end
            S_ARB: begin
                if (host_pending && (!poll_pending || last_poll)) begin
                    grant_host = 1'b1;
                    next_state = S_ISSUE;
                end else if (poll_pending) begin
                    grant_poll = 1'b1;
                    next_state = S_ISSUE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (eng_done)                         next_state = S_COMPLETE;
                else if (wdog_inc == TIMEOUT_CYCLES) next_state = S_TIMEOUT;
            end
            S_COMPLETE: next_state = S_IDLE;
            S_TIMEOUT:  next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
        host_pending_d = grant_host ? 1'b0 : (host_edge ? 1'b1 : host_pending);
        poll_pending_d = grant_poll ? 1'b0 : (poll_wrap ? 1'b1 : poll_pending);
        owner_host_d   = grant_host | (owner_host & ~grant_poll);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            host_trig_q  <= 1'b0;
            host_pending <= 1'b0;
            poll_pending <= 1'b0;
            owner_host   <= 1'b0;
            last_poll    <= 1'b1;
            host_cmd     <= '0;
            wdog         <= '0;
            host_busy    <= 1'b0;
            host_done    <= 1'b0;
            host_err     <= 1'b0;
            host_rdata   <= '0;
            temperature  <= '0;
            temp_valid   <= 1'b0;
            eng_start    <= 1'b0;
            eng_abort    <= 1'b0;
            eng_rnw      <= 1'b0;
            eng_dev_addr <= '0;
            eng_reg      <= '0;
            eng_wdata    <= '0;
            eng_len      <= '0;
        end else begin
            host_trig_q  <= host_trig;
            host_pending <= host_pending_d;
            poll_pending <= poll_pending_d;
            owner_host   <= owner_host_d;
            // Capture only accepted requests; an edge seen while pending is dropped.
            if (host_edge && !host_pending) begin
                host_cmd.rnw     <= host_rnw;
                host_cmd.regaddr <= host_reg;
                host_cmd.wdata   <= host_wdata;
                host_cmd.len     <= (host_len == 2'd1) ? 2'd1 : 2'd2;
            end
            if (grant_host || grant_poll) begin
                last_poll    <= grant_poll;
                eng_dev_addr <= DEV_ADDR;
                {eng_rnw, eng_reg, eng_wdata, eng_len} <= grant_host ? host_cmd : poll_cmd;
            end
            eng_start <= grant_host | grant_poll;
            eng_abort <= (next_state == S_TIMEOUT);
            wdog      <= (cur_state == S_WAIT) ? wdog_inc : '0;
            host_done <= owner_host && (next_state == S_COMPLETE || next_state == S_TIMEOUT);
            host_busy <= host_pending_d
                         | (owner_host_d && (next_state == S_ISSUE || next_state == S_WAIT));
            if (owner_host && next_state == S_COMPLETE) begin
                host_err <= eng_ack_err;
                if (eng_rnw) host_rdata <= eng_rdata;
            end
            if (owner_host && next_state == S_TIMEOUT) host_err <= 1'b1;
`ifdef I2C_SCHED_POLL_EN
            if (!owner_host && next_state == S_COMPLETE && !eng_ack_err) begin
                temperature <= eng_rdata;
                temp_valid  <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler: host table, watchdog, in-flight requests, reset and
// (with I2C_SCHED_POLL_EN) poll and collision sequences.
module tb_i2c_txn_scheduler;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_trig = 1'b0;
    logic        host_rnw = 1'b0;
    logic [7:0]  host_reg = '0;
    logic [15:0] host_wdata = '0;
    logic [1:0]  host_len = '0;
    logic        host_busy, host_done, host_err;
    logic [15:0] host_rdata, temperature;
    logic        temp_valid, eng_start, eng_abort, eng_rnw;
    logic [6:0]  eng_dev_addr;
    logic [7:0]  eng_reg;
    logic [15:0] eng_wdata;
    logic [1:0]  eng_len;
    logic        eng_done = 1'b0;
    logic        eng_ack_err = 1'b0;
    logic [15:0] eng_rdata = '0;
    logic [7:0]  state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    i2c_txn_scheduler #(
        .POLL_PERIOD    (32'd200),
        .DEV_ADDR       (7'h48),
        .TEMP_REG       (8'h00),
        .TIMEOUT_CYCLES (24'd50)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .host_trig    (host_trig),
        .host_rnw     (host_rnw),
        .host_reg     (host_reg),
        .host_wdata   (host_wdata),
        .host_len     (host_len),
        .host_busy    (host_busy),
        .host_done    (host_done),
        .host_err     (host_err),
        .host_rdata   (host_rdata),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .eng_start    (eng_start),
        .eng_abort    (eng_abort),
        .eng_rnw      (eng_rnw),
        .eng_dev_addr (eng_dev_addr),
        .eng_reg      (eng_reg),
        .eng_wdata    (eng_wdata),
        .eng_len      (eng_len),
        .eng_done     (eng_done),
        .eng_ack_err  (eng_ack_err),
        .eng_rdata    (eng_rdata),
        .state        (state)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        rnw;
        logic [7:0]  r;
        logic [15:0] wd;
        logic [1:0]  ln;
        logic [15:0] rsp;
        logic        err;
        int          lat;
        logic [1:0]  exp_len;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(negedge sys_clk);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        host_trig = 1'b0;
        eng_done = 1'b0;
        eng_ack_err = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // From an idle FSM at a negedge: raise the trigger and follow it to ISSUE.
    task automatic host_start(input logic rnw, input logic [7:0] r, input logic [15:0] wd,
                              input logic [1:0] ln, input logic [1:0] exp_len);
        host_rnw = rnw;
        host_reg = r;
        host_wdata = wd;
        host_len = ln;
        host_trig = 1'b1;
        tick();
        chk("arb_state", state, 8'h01);
        chk("busy_rise", host_busy, 1'b1);
        chk("no_early_start", eng_start, 1'b0);
        host_trig = 1'b0;
        tick();
        chk("issue_state", state, 8'h02);
        chk("eng_start", eng_start, 1'b1);
        chk("host_cmd", {eng_rnw, eng_dev_addr, eng_reg, eng_wdata, eng_len},
            {rnw, 7'h48, r, wd, exp_len});
    endtask

    // From the ISSUE negedge: engine answers in the lat-th WAIT cycle; ends in COMPLETE.
    task automatic eng_respond(input int lat, input logic [15:0] data, input logic err);
        tick();
        chk("start_once", eng_start, 1'b0);
        chk("wait_state", state, 8'h03);
        for (int i = 1; i < lat; i++) tick();
        eng_done = 1'b1;
        eng_rdata = data;
        eng_ack_err = err;
        tick();
        eng_done = 1'b0;
        eng_ack_err = 1'b0;
        eng_rdata = '0;
        chk("complete_state", state, 8'h04);
        chk("no_abort", eng_abort, 1'b0);
    endtask

    task automatic wait_start(input int bound);
        int n = 0;
        while (eng_start !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("start_seen", eng_start, 1'b1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h0B, 16'h0000, 2'd1, 16'h00CB, 1'b0, 3, 2'd1, 16'h00CB, 1'b0};
        vecs[1] = '{1'b0, 8'h03, 16'h1234, 2'd2, 16'hBEEF, 1'b0, 2, 2'd2, 16'h00CB, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 16'h0000, 2'd0, 16'h0C80, 1'b0, 1, 2'd2, 16'h0C80, 1'b0};
        vecs[3] = '{1'b1, 8'h02, 16'h0000, 2'd3, 16'h5A5A, 1'b1, 4, 2'd2, 16'h5A5A, 1'b1};
        vecs[4] = '{1'b0, 8'h01, 16'h00AA, 2'd1, 16'h1111, 1'b1, 2, 2'd1, 16'h5A5A, 1'b1};
        vecs[5] = '{1'b1, 8'h0B, 16'h0000, 2'd1, 16'h00C3, 1'b0, 1, 2'd1, 16'h00C3, 1'b0};

        // Reset values while reset is held
        tick();
        chk("rst_outputs", {host_busy, host_done, host_err, host_rdata, temperature, temp_valid,
                            eng_start, eng_abort, eng_rnw, eng_dev_addr, eng_reg, eng_wdata,
                            eng_len, state}, 64'h0);
        do_reset();
        tick();

        // Stray engine done while idle is ignored
        eng_done = 1'b1;
        eng_ack_err = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_ack_err = 1'b0;
        tick();
        chk("stray_done_state", state, 8'h00);
        chk("stray_done_host", {host_done, host_err}, 2'b00);

        for (int i = 0; i < 6; i++) begin
            host_start(vecs[i].rnw, vecs[i].r, vecs[i].wd, vecs[i].ln, vecs[i].exp_len);
            eng_respond(vecs[i].lat, vecs[i].rsp, vecs[i].err);
            chk("host_done", host_done, 1'b1);
            chk("host_err", host_err, vecs[i].exp_err);
            chk("host_rdata", host_rdata, vecs[i].exp_rdata);
            chk("busy_fall", host_busy, 1'b0);
            tick();
            chk("done_pulse", host_done, 1'b0);
            chk("back_idle", state, 8'h00);
        end
        chk("no_temp_from_host", {temp_valid, temperature}, 17'h0);

        // Watchdog expiry, then done landing exactly on the expiry cycle
        do_reset();
        host_start(1'b1, 8'h05, 16'h0000, 2'd2, 2'd2);
        tick();
        for (int i = 2; i <= 50; i++) tick();
        chk("wait50_state", state, 8'h03);
        chk("abort_not_yet", eng_abort, 1'b0);
        tick();
        chk("timeout_state", state, 8'h05);
        chk("abort_pulse", eng_abort, 1'b1);
        chk("timeout_done", host_done, 1'b1);
        chk("timeout_err", host_err, 1'b1);
        chk("timeout_busy", host_busy, 1'b0);
        tick();
        chk("timeout_idle", state, 8'h00);
        chk("abort_once", {eng_abort, host_done}, 2'b00);
        host_start(1'b1, 8'h06, 16'h0000, 2'd1, 2'd1);
        eng_respond(50, 16'h0042, 1'b0);
        chk("expiry_done_err", host_err, 1'b0);
        chk("expiry_done_rdata", host_rdata, 16'h0042);
        tick();
        chk("expiry_no_abort", eng_abort, 1'b0);

        // Request arriving in flight is queued; a second edge while queued is dropped
        do_reset();
        host_start(1'b1, 8'h0B, 16'h0000, 2'd1, 2'd1);
        tick();
        host_rnw = 1'b0;
        host_reg = 8'h22;
        host_wdata = 16'hA5A5;
        host_len = 2'd2;
        host_trig = 1'b1;
        tick();
        chk("busy_inflight", host_busy, 1'b1);
        host_trig = 1'b0;
        tick();
        host_reg = 8'h33;
        host_trig = 1'b1;
        tick();
        host_trig = 1'b0;
        eng_done = 1'b1;
        eng_rdata = 16'h00D1;
        tick();
        eng_done = 1'b0;
        eng_rdata = '0;
        chk("q_complete", {state, host_done, host_busy}, {8'h04, 1'b1, 1'b1});
        chk("q_rdata", host_rdata, 16'h00D1);
        tick();
        chk("q_idle", {state, host_done, host_busy}, {8'h00, 1'b0, 1'b1});
        tick();
        chk("q_arb", state, 8'h01);
        tick();
        chk("q_issue", {state, eng_start}, {8'h02, 1'b1});
        chk("q_cmd", {eng_rnw, eng_dev_addr, eng_reg, eng_wdata, eng_len},
            {1'b0, 7'h48, 8'h22, 16'hA5A5, 2'd2});
        eng_respond(1, 16'hFFFF, 1'b1);
        chk("q_nack", {host_done, host_err, host_busy}, 3'b110);
        chk("q_write_keeps_rdata", host_rdata, 16'h00D1);
        tick();

        // Asynchronous reset while waiting on the engine
        host_start(1'b1, 8'h44, 16'h0000, 2'd2, 2'd2);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {host_busy, host_done, host_err, host_rdata, eng_start, eng_abort,
                          eng_rnw, eng_dev_addr, eng_reg, eng_len, state}, 64'h0);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        tick();
        tick();
        tick();
        chk("rst_cleared_pending", {state, eng_start, host_busy}, 10'h0);

`ifdef I2C_SCHED_POLL_EN
        // Periodic polls: good result, then NACK keeps the old temperature
        do_reset();
        wait_start(300);
        chk("poll1_cycle", cyc, 201);
        chk("poll_cmd", {eng_rnw, eng_dev_addr, eng_reg, eng_wdata, eng_len},
            {1'b1, 7'h48, 8'h00, 16'h0000, 2'd2});
        eng_respond(2, 16'h0C80, 1'b0);
        chk("poll_temp", {temp_valid, temperature}, {1'b1, 16'h0C80});
        chk("poll_no_host_done", host_done, 1'b0);
        tick();
        wait_start(300);
        chk("poll2_cycle", cyc, 401);
        eng_respond(1, 16'h7777, 1'b1);
        chk("poll_nack_temp", {temp_valid, temperature}, {1'b1, 16'h0C80});

        // Collision right after reset goes to host; after a host grant it goes to poll
        do_reset();
        while (cyc < 199) tick();
        host_rnw = 1'b1;
        host_reg = 8'h0B;
        host_len = 2'd1;
        host_trig = 1'b1;
        tick();
        chk("col1_arb", state, 8'h01);
        host_trig = 1'b0;
        tick();
        chk("col1_host_first", {eng_start, eng_reg, eng_len}, {1'b1, 8'h0B, 2'd1});
        eng_respond(1, 16'h00CB, 1'b0);
        chk("col1_host_done", host_done, 1'b1);
        wait_start(10);
        chk("col1_poll_next", {eng_reg, eng_len}, {8'h00, 2'd2});
        eng_respond(1, 16'h0C81, 1'b0);
        tick();
        host_start(1'b0, 8'h01, 16'h0060, 2'd1, 2'd1);
        eng_respond(1, 16'h0000, 1'b0);
        tick();
        while (cyc < 399) tick();
        host_reg = 8'h0C;
        host_trig = 1'b1;
        tick();
        host_trig = 1'b0;
        tick();
        chk("col2_poll_first", {eng_start, eng_reg, eng_len}, {1'b1, 8'h00, 2'd2});
        eng_respond(1, 16'h0D00, 1'b0);
        chk("col2_temp", temperature, 16'h0D00);
        wait_start(10);
        chk("col2_host_next", {eng_reg, eng_len}, {8'h0C, 2'd1});
        eng_respond(1, 16'h00C9, 1'b0);
        chk("col2_host_done", {host_done, host_rdata}, {1'b1, 16'h00C9});
`else
        // Without the poll feature nothing is ever issued unprompted
        do_reset();
        begin
            int starts = 0;
            for (int i = 0; i < 450; i++) begin
                tick();
                if (eng_start === 1'b1) starts++;
            end
            chk("no_poll_starts", starts, 0);
        end
        chk("no_temp", {temp_valid, temperature}, 17'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
